pci_target_burst: RTL

PCI_TARGET_BURST -- requirements
Module: pci_target_burst

---
 rtl/pci_tgt_pkg.sv | 24 ++
 rtl/pci_tgt_mem.sv | 38 +++
 rtl/pci_target_burst.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/pci_tgt_pkg.sv
// pci_tgt_pkg -- shared definitions for the PCI burst target.
//   CMD_MEM_READ / CMD_MEM_WRITE : bus command codes the target claims
//   tgt_state_e                  : target state machine states
//   even_parity()                : PAR value for one AD/CBE data phase
package pci_tgt_pkg;

  localparam logic [3:0] CMD_MEM_READ  = 4'b0110;
  localparam logic [3:0] CMD_MEM_WRITE = 4'b0111;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WR_DATA   = 3'd1,
    RD_TA     = 3'd2,
    RD_DATA   = 3'd3,
    STOP_WAIT = 3'd4,
    BACKOFF   = 3'd5
  } tgt_state_e;

  // Even parity: the number of ones across AD, CBE and PAR is even.
  function automatic logic even_parity(input logic [31:0] ad, input logic [3:0] cbe);
    return ^{ad, cbe};
  endfunction

endpackage

// File: rtl/pci_tgt_mem.sv
// pci_tgt_mem -- DEPTH x 32 byte-enabled RAM for the PCI burst target.
// Combinational read, synchronous write; contents are never reset.
//   i_clk   : clock
//   i_we    : write strobe for the word at i_addr
//   i_addr  : word index (shared by read and write)
//   i_be    : active-high byte enables, bit i covers byte i
//   i_wdata : write data
//   o_rdata : word currently addressed by i_addr
module pci_tgt_mem
  import pci_tgt_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_addr,
  input  logic [3:0]    i_be,
  input  logic [31:0]   i_wdata,
  output logic [31:0]   o_rdata
);

  logic [31:0] r_mem [DEPTH];

  // Byte-masked write; bytes with a cleared enable keep their old value.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      for (int b = 0; b < 4; b++) begin
        if (i_be[b]) begin
          r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
        end
      end
    end
  end

  assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/pci_target_burst.sv
// pci_target_burst -- PCI memory target with linear burst support over a
// DEPTH-word window starting at BASE_ADDR (BASE_ADDR assumed word aligned).
//   clock        : single clock, rising edge
//   reset        : asynchronous active-low reset
//   AD           : multiplexed address/data bus (inout)
//   CBE          : command in the address phase, active-low byte enables after
//   FRAME, IRDY  : active-low master controls
//   TRDY, DEVSEL, STOP : active-low target controls (registered)
//   AD_direction : 1 = master drives AD, 0 = target drives AD
//   PAR          : even parity one clock after each read data phase
//                  (only present when PCI_TGT_PARITY_EN is defined)
module pci_target_burst
  import pci_tgt_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          DEPTH     = 16
) (
  input  logic        clock,
  input  logic        reset,
  inout  wire  [31:0] AD,
  input  logic [3:0]  CBE,
  input  logic        FRAME,
  input  logic        IRDY,
  output logic        TRDY,
  output logic        DEVSEL,
  output logic        STOP,
  output logic        AD_direction
`ifdef PCI_TGT_PARITY_EN
  ,
  output wire         PAR
`endif
);

  localparam int            AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

  tgt_state_e    r_state;
  logic [AW-1:0] r_index;
  logic          r_frame_prev;
  logic          r_trdy;
  logic          r_devsel;
  logic          r_stop;
  logic          r_ad_dir;
  logic          r_ad_oe;

  logic [32:0]   w_diff;
  logic          w_in_range;
  logic [AW-1:0] w_addr_idx;
  logic [AW-1:0] w_next_idx;
  logic          w_addr_phase;
  logic          w_claim_wr;
  logic          w_claim_rd;
  logic          w_we;
  logic [31:0]   w_rd_data;
  logic          w_unused_low_bits;

  // One extra bit catches addresses below BASE_ADDR as a borrow.
  assign w_diff            = {1'b0, AD} - {1'b0, BASE_ADDR};
  assign w_in_range        = (w_diff[32:AW+2] == {(31 - AW){1'b0}});
  assign w_addr_idx        = w_diff[AW+1:2];
  assign w_unused_low_bits = ^w_diff[1:0];
  assign w_next_idx        = r_index + AW'(1'b1);

  // Address phase = first edge with FRAME low after an edge with FRAME high.
  assign w_addr_phase = ~FRAME & r_frame_prev;
  assign w_claim_wr   = w_addr_phase & w_in_range & (CBE == CMD_MEM_WRITE);
  assign w_claim_rd   = w_addr_phase & w_in_range & (CBE == CMD_MEM_READ);

  // TRDY is always low in WR_DATA, so IRDY alone qualifies a write transfer.
  assign w_we = (r_state == WR_DATA) & ~IRDY;

  pci_tgt_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .i_clk   (clock),
    .i_we    (w_we),
    .i_addr  (r_index),
    .i_be    (~CBE),
    .i_wdata (AD),
    .o_rdata (w_rd_data)
  );

  assign AD           = r_ad_oe ? w_rd_data : {32{1'bz}};
  assign TRDY         = r_trdy;
  assign DEVSEL       = r_devsel;
  assign STOP         = r_stop;
  assign AD_direction = r_ad_dir;

  // Target state machine with registered bus control outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_index      <= {AW{1'b0}};
      r_frame_prev <= 1'b1;
      r_trdy       <= 1'b1;
      r_devsel     <= 1'b1;
      r_stop       <= 1'b1;
      r_ad_dir     <= 1'b1;
      r_ad_oe      <= 1'b0;
    end else begin
      r_frame_prev <= FRAME;
      case (r_state)
        IDLE: begin
          if (w_claim_wr) begin
            r_state  <= WR_DATA;
            r_index  <= w_addr_idx;
            r_devsel <= 1'b0;
            r_trdy   <= 1'b0;
            // A burst that starts on the last word disconnects on it.
            r_stop   <= (w_addr_idx == LAST_IDX) ? 1'b0 : 1'b1;
            r_ad_dir <= 1'b1;
            r_ad_oe  <= 1'b0;
          end else if (w_claim_rd) begin
            r_state  <= RD_TA;
            r_index  <= w_addr_idx;
            r_devsel <= 1'b0;
            r_trdy   <= 1'b1;
            r_stop   <= 1'b1;
            r_ad_dir <= 1'b0;
            r_ad_oe  <= 1'b0;
          end else begin
            r_state  <= IDLE;
            r_devsel <= 1'b1;
            r_trdy   <= 1'b1;
            r_stop   <= 1'b1;
            r_ad_dir <= 1'b1;
            r_ad_oe  <= 1'b0;
          end
        end
        RD_TA: begin
          if (FRAME & IRDY) begin
            r_state  <= BACKOFF;
            r_devsel <= 1'b1;
            r_trdy   <= 1'b1;
            r_stop   <= 1'b1;
            r_ad_dir <= 1'b1;
            r_ad_oe  <= 1'b0;
          end else begin
            r_state <= RD_DATA;
            r_trdy  <= 1'b0;
            r_ad_oe <= 1'b1;
            r_stop  <= (r_index == LAST_IDX) ? 1'b0 : 1'b1;
          end
        end
        WR_DATA, RD_DATA: begin
          if (FRAME & IRDY) begin
            // Master abort: leave without a transfer.
            r_state  <= BACKOFF;
            r_devsel <= 1'b1;
            r_trdy   <= 1'b1;
            r_stop   <= 1'b1;
            r_ad_dir <= 1'b1;
            r_ad_oe  <= 1'b0;
          end else if (!IRDY) begin
            // Transfer; for reads the next word appears on AD immediately.
            r_index <= w_next_idx;
            if (FRAME) begin
              r_state  <= BACKOFF;
              r_devsel <= 1'b1;
              r_trdy   <= 1'b1;
              r_stop   <= 1'b1;
              r_ad_dir <= 1'b1;
              r_ad_oe  <= 1'b0;
            end else if (r_index == LAST_IDX) begin
              // Disconnect-with-data done: hold STOP until FRAME rises.
              r_state <= STOP_WAIT;
              r_trdy  <= 1'b1;
              r_stop  <= 1'b0;
              r_ad_oe <= 1'b0;
            end else begin
              r_state <= r_state;
              r_stop  <= (w_next_idx == LAST_IDX) ? 1'b0 : 1'b1;
            end
          end else begin
            r_state <= r_state;
          end
        end
        STOP_WAIT: begin
          if (FRAME) begin
            r_state  <= BACKOFF;
            r_devsel <= 1'b1;
            r_trdy   <= 1'b1;
            r_stop   <= 1'b1;
            r_ad_dir <= 1'b1;
            r_ad_oe  <= 1'b0;
          end else begin
            r_state <= STOP_WAIT;
          end
        end
        BACKOFF: begin
          // Outputs were released on entry; a new address waits for IDLE.
          r_state <= IDLE;
        end
        default: begin
          r_state  <= IDLE;
          r_devsel <= 1'b1;
          r_trdy   <= 1'b1;
          r_stop   <= 1'b1;
          r_ad_dir <= 1'b1;
          r_ad_oe  <= 1'b0;
        end
      endcase
    end
  end

`ifdef PCI_TGT_PARITY_EN
  logic r_par;
  logic r_par_oe;

  // PAR trails each clock the target drove AD by exactly one clock.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_par    <= 1'b0;
      r_par_oe <= 1'b0;
    end else begin
      r_par    <= even_parity(AD, CBE);
      r_par_oe <= r_ad_oe;
    end
  end

  assign PAR = r_par_oe ? r_par : 1'bz;
`endif

endmodule
